// File: rtl/alu_control_unit_if.sv
// Memory handshake bundle shared by the sequencer (master) and memory (slave).
// mem_req/mem_we/mem_addr/mem_wdata : request side, driven by the sequencer
// mem_rdata/mem_ready               : response side, driven by memory
interface alu_control_unit_if;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/alu_control_unit.sv
// Multi-cycle fetch/decode/execute sequencer in front of a 16-bit registered ALU.
// Owns PC, IR and the {C,N,V,Z} flag register.
// clk, rst          : clock, synchronous active-high reset
// mem               : instruction/data memory handshake (master side)
// rf_raddr*/rdata*  : register-file read ports (combinational data)
// rf_we/waddr/wdata : register-file write port, one-cycle strobe
// alu_*             : ALU function/operands/flags out, registered result in
// flags, pc         : architectural state
// instr_done        : one-cycle pulse per retired instruction
module alu_control_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                      clk,
  input  logic                      rst,
  alu_control_unit_if.master        mem,
  output logic [2:0]                rf_raddr0,
  output logic [2:0]                rf_raddr1,
  input  logic [15:0]               rf_rdata0,
  input  logic [15:0]               rf_rdata1,
  output logic                      rf_we,
  output logic [2:0]                rf_waddr,
  output logic [15:0]               rf_wdata,
  output logic [3:0]                alu_func,
  output logic [15:0]               alu_op0,
  output logic [15:0]               alu_op1,
  output logic                      alu_flag_en,
  output logic [3:0]                alu_flag_in,
  input  logic [15:0]               alu_q,
  input  logic [3:0]                alu_flag_out,
  output logic [3:0]                flags,
  output logic [15:0]               pc,
  output logic                      instr_done
);
  localparam int unsigned DW = 16;

  localparam logic [3:0] OP_JMP = 4'h0;
  localparam logic [3:0] OP_LD  = 4'h8;
  localparam logic [3:0] OP_ST  = 4'h9;
  localparam logic [3:0] OP_MOV = 4'hA;
  localparam logic [3:0] OP_BEQ = 4'hB;
  localparam logic [3:0] OP_BNE = 4'hC;
  localparam logic [3:0] OP_BLT = 4'hD;
  localparam logic [3:0] OP_BGT = 4'hE;
  localparam logic [3:0] OP_CMP = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_CAPTURE, S_MEM, S_WB
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] pc_q, pc_d;
  logic [DW-1:0] ir_q, ir_d;
  logic [3:0]    flags_q, flags_d;
  logic [DW-1:0] op0_q, op0_d;
  logic [DW-1:0] op1_q, op1_d;
  logic [DW-1:0] st_data_q, st_data_d;
  logic [DW-1:0] result_q, result_d;
  logic [DW-1:0] ld_data_q, ld_data_d;

  // Instruction field decode
  logic [3:0]    op;
  logic [2:0]    rd, rs, rs2;
  logic          imm_sel;
  logic [DW-1:0] imm_sx;
  logic          is_st, is_mem, flag_op, rf_wr_op, br_taken;

  assign op       = ir_q[15:12];
  assign rd       = ir_q[11:9];
  assign rs       = ir_q[8:6];
  assign imm_sel  = ir_q[5];
  assign rs2      = ir_q[2:0];
  assign imm_sx   = {{(DW-5){ir_q[4]}}, ir_q[4:0]};
  assign is_st    = (op == OP_ST);
  assign is_mem   = (op == OP_LD) || is_st;
  assign flag_op  = ((op >= 4'h1) && (op <= 4'h7)) || (op == OP_CMP);
  assign rf_wr_op = ((op >= 4'h1) && (op <= 4'h7)) || (op == OP_MOV) || (op == OP_LD);

  // Branch condition on {C,N,V,Z}
  always_comb begin
    br_taken = 1'b0;
    case (op)
      OP_BEQ:  br_taken = flags_q[0];
      OP_BNE:  br_taken = !flags_q[0];
      OP_BLT:  br_taken = flags_q[2] && !flags_q[0];
      OP_BGT:  br_taken = !flags_q[2] && !flags_q[0];
      default: br_taken = 1'b0;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      flags_q   <= '0;
      op0_q     <= '0;
      op1_q     <= '0;
      st_data_q <= '0;
      result_q  <= '0;
      ld_data_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      flags_q   <= flags_d;
      op0_q     <= op0_d;
      op1_q     <= op1_d;
      st_data_q <= st_data_d;
      result_q  <= result_d;
      ld_data_q <= ld_data_d;
    end
  end

  // Next-state, datapath updates and output decode
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    flags_d   = flags_q;
    op0_d     = op0_q;
    op1_d     = op1_q;
    st_data_d = st_data_q;
    result_d  = result_q;
    ld_data_d = ld_data_q;

    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    rf_raddr0     = '0;
    rf_raddr1     = '0;
    rf_we         = 1'b0;
    rf_waddr      = '0;
    rf_wdata      = '0;
    alu_func      = '0;
    alu_op0       = '0;
    alu_op1       = '0;
    alu_flag_en   = 1'b0;
    alu_flag_in   = '0;
    flags         = '0;
    pc            = '0;
    instr_done    = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (mem.mem_ready) begin
          ir_d    = mem.mem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // Stores always address with the immediate; port 1 carries rd data
        op0_d     = rf_rdata0;
        op1_d     = (imm_sel || is_st) ? imm_sx : rf_rdata1;
        st_data_d = rf_rdata1;
        state_d   = S_EXEC;
      end
      S_EXEC: state_d = S_CAPTURE;
      S_CAPTURE: begin
        result_d = alu_q;
        if (flag_op) flags_d = alu_flag_out;
        state_d = is_mem ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (mem.mem_ready) begin
          if (!is_st) ld_data_d = mem.mem_rdata;
          state_d = S_WB;
        end
      end
      S_WB: begin
        if ((op == OP_JMP) || br_taken) pc_d = result_q;
        else                            pc_d = pc_q + 16'd1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Every output is forced quiet while reset is held
    if (!rst) begin
      flags = flags_q;
      pc    = pc_q;
      case (state_q)
        S_FETCH: begin
          mem.mem_req  = 1'b1;
          mem.mem_addr = pc_q;
        end
        S_DECODE: begin
          rf_raddr0 = rs;
          rf_raddr1 = is_st ? rd : rs2;
        end
        S_EXEC, S_CAPTURE: begin
          alu_func    = op;
          alu_op0     = op0_q;
          alu_op1     = op1_q;
          alu_flag_en = flag_op;
          alu_flag_in = {1'b0, flags_q[2:0]};
        end
        S_MEM: begin
          mem.mem_req   = 1'b1;
          mem.mem_we    = is_st;
          mem.mem_addr  = result_q;
          mem.mem_wdata = is_st ? st_data_q : 16'h0000;
        end
        S_WB: begin
          rf_we      = rf_wr_op;
          rf_waddr   = rf_wr_op ? rd : 3'd0;
          rf_wdata   = !rf_wr_op ? 16'h0000 : ((op == OP_LD) ? ld_data_q : result_q);
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/alu_control_unit.md
Name: alu_control_unit

Overview:
- Multi-cycle fetch/decode/execute sequencer sitting directly upstream of the 16-bit ALU.
- Owns PC, instruction register (IR) and the architectural flag register {C,N,V,Z}.
- Fetches 16-bit instructions over a shared single-port memory handshake and drives the ALU func/operand/flag inputs.
- Captures the ALU's registered result, then performs register-file writeback, memory load/store or PC update.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
mem_req  output  1  memory request, held until accepted
mem_we  output  1  1 = write (ST), 0 = read
mem_addr  output  16  memory address
mem_wdata  output  16  store data
mem_rdata  input  16  read data, valid when mem_ready=1
mem_ready  input  1  transaction completes on an edge where mem_req=1 and mem_ready=1
rf_raddr0  output  3  register-file read port 0 address (rs)
rf_raddr1  output  3  read port 1 address (rs2, or rd for ST)
rf_rdata0  input  16  combinational read data port 0
rf_rdata1  input  16  combinational read data port 1
rf_we  output  1  register write strobe, one-cycle pulse
rf_waddr  output  3  write address (rd)
rf_wdata  output  16  write data
alu_func  output  4  ALU function code
alu_op0  output  16  ALU operand 0
alu_op1  output  16  ALU operand 1
alu_flag_en  output  1  ALU flag update enable
alu_flag_in  output  4  flags presented to ALU
alu_q  input  16  ALU result, registered by the ALU one clock after its inputs
alu_flag_out  input  4  ALU flags {C,N,V,Z}, same timing as alu_q
flags  output  4  architectural flag register {C,N,V,Z}
pc  output  16  current PC
instr_done  output  1  one-cycle pulse per retired instruction

Behaviour:
- Instruction format:
  - op = IR[15:12], using the ALU codes: 0 JMP, 1 ADD, 2 SUB, 3 LSL, 4 LSR, 5 AND, 6 OR, 7 XOR, 8 LD, 9 ST, A MOV, B BEQ, C BNE, D BLT, E BGT, F CMP.
  - rd = IR[11:9], rs = IR[8:6], imm_sel = IR[5].
  - OP1 = imm_sel ? sign-extended IR[4:0] : reg[IR[2:0]].
- States: FETCH -> DECODE -> EXEC -> CAPTURE -> (MEM if LD/ST) -> WB -> FETCH. Encoded state is internal.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=pc.
  - On the accepting edge: IR<=mem_rdata, go to DECODE, and mem_req=0 in the next cycle.
  - Zero wait states are allowed (ready in the first request cycle).
- DECODE:
  - rf_raddr0=rs; rf_raddr1 = (op==ST) ? rd : IR[2:0].
  - Latch op0=rf_rdata0; latch op1 per imm_sel.
  - ST always uses the sign-extended immediate as op1.
- EXEC:
  - Drive alu_func=op, alu_op0, alu_op1.
  - alu_flag_in = {1'b0, flags[2:0]}: carry-in is never injected.
  - alu_flag_en = 1 for ops 1–7 and F, else 0.
  - All ALU outputs are held stable through CAPTURE.
- CAPTURE:
  - Latch result<=alu_q.
  - flags<=alu_flag_out for ops 1–7 and F; flags are otherwise unchanged.
- MEM:
  - LD: mem_req=1, mem_we=0, mem_addr=result; latch mem_rdata on accept.
  - ST: mem_req=1, mem_we=1, mem_addr=result, mem_wdata=latched rd value (rf_rdata1 from DECODE).
  - Wait indefinitely for ready.
- WB:
  - ALU ops 1–7 and A: rf_we=1, rf_waddr=rd, rf_wdata=result.
  - LD: rf_we=1, rf_wdata=loaded data.
  - JMP: pc<=result.
  - Branches: pc<=result if taken, else pc+1. Conditions: BEQ Z=1; BNE Z=0; BLT N=1&Z=0; BGT N=0&Z=0.
  - All other ops: pc<=pc+1.
  - CMP and ST perform no rf write.
  - instr_done=1 for exactly this cycle.
- Latency with zero-wait memory: 5 cycles for non-memory ops, 6 for LD/ST.
- pc+1 wraps 16'hFFFF->16'h0000.
- Reset:
  - Applies from any state, including mid-handshake.
  - Next-edge values: state=FETCH, pc=RESET_PC, IR=0, flags=0.
  - mem_req, mem_we, rf_we, alu_flag_en and instr_done are 0 while rst=1.
  - All other data outputs are 0 while rst=1.
  - An abandoned memory transaction is not retried; fetch restarts at RESET_PC after rst deasserts.
- mem_ready while mem_req=0 is ignored.

Test Plan:
- Reset/fetch: assert rst mid-FETCH with RESET_PC=16'h0010 -> mem_req drops while rst=1; first request after rst deasserts has mem_addr=16'h0010.
- ADD immediate: r1=16'h7FFF, instr 16'h1461 (ADD r2,r1,#1), zero-wait memory -> rf_we in cycle 5 with waddr=2, wdata=16'h8000; flags=4'b0110 (N,V set); pc=pc+1.
- CMP then BEQ:
  - r3=r4=16'h0005, CMP r3,r4 -> Z=1, no rf_we.
  - BEQ with r5=16'h0040 -> pc=16'h0040.
  - Repeat with r4=6 -> pc advances by 1.
- LD with 3 wait states: r1=16'h0100, LD r2,[r1,#-1] -> mem_addr=16'h00FF held for 4 cycles with mem_req=1, then rf_wdata equals the memory word; 9 cycles total.
- ST: r6=16'h0200, r7=16'hBEEF, ST r7,[r6,#2] -> mem_we=1, mem_addr=16'h0202, mem_wdata=16'hBEEF; no rf_we; flags unchanged.
- PC wrap: pc=16'hFFFF executing AND -> next fetch at mem_addr=16'h0000; instr_done pulses exactly once per instruction.
